// File: rtl/apb_slave_regs.sv
// APB slave with a bank of 32-bit read/write registers, programmable wait states
// and a free-running count of completed transfers.
module apb_slave_regs #(
  parameter int SLAVE_IDX   = 0,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic [3:0]  psel,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic        penable,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic [15:0] xfer_cnt
);

  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [29:0] NUM_REGS_W = 30'(NUM_REGS);
  localparam logic [2:0]  WAIT_LD    = 3'(WAIT_CYCLES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             state_q;
  logic [2:0]         wcnt_q;
  logic [15:0]        xfer_cnt_q;
  logic [15:0]        xfer_cnt_d;
  logic [31:0]        regs_q [NUM_REGS];

  logic               sel;
  logic               in_range;
  logic               complete;
  logic [IDX_W-1:0]   idx;
  logic               unused_bits;

  assign sel         = psel[SLAVE_IDX];
  assign idx         = paddr[2 +: IDX_W];
  assign in_range    = (paddr[31:2] < NUM_REGS_W);
  assign unused_bits = ^{psel, paddr[1:0]};

  // pready is purely a function of the FSM so the master sees it in the same cycle.
  assign pready     = (state_q == ACCESS) && (wcnt_q == 3'd0);
  assign complete   = pready && sel && penable;
  assign prdata     = (pready && !pwrite && in_range) ? regs_q[idx] : 32'h0;
  assign xfer_cnt_d = xfer_cnt_q + 16'd1;
  assign xfer_cnt   = xfer_cnt_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel && !penable) begin
            state_q <= ACCESS;
            wcnt_q  <= WAIT_LD;
          end
        end
        ACCESS: begin
          // Deselect aborts; a fresh setup phase restarts the wait count.
          if (!sel) begin
            state_q <= IDLE;
          end else if (!penable) begin
            wcnt_q <= WAIT_LD;
          end else if (wcnt_q != 3'd0) begin
            wcnt_q <= wcnt_q - 3'd1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (complete && pwrite && in_range) begin
      regs_q[idx] <= pwdata;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      xfer_cnt_q <= 16'h0;
    end else if (complete) begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001: Parameter SLAVE_IDX, default 0, SHALL select which psel bit (0..3) addresses this slave.
REQ-002: Parameter NUM_REGS, default 16, SHALL set the count of 32-bit registers (power of two, 2..256).
REQ-003: Parameter WAIT_CYCLES, default 1, SHALL set the wait states inserted per transfer (0..7).
REQ-004: pclk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005: preset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: psel  input  4  SHALL carry one-hot slave selects; only psel[SLAVE_IDX] is used.
REQ-007: paddr  input  32  SHALL carry the byte address.
REQ-008: pwrite  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-009: penable  input  1  SHALL be 0 in the setup phase and 1 in the access phase.
REQ-010: pwdata  input  32  SHALL carry the write data.
REQ-011: prdata  output  32  SHALL carry the read data.
REQ-012: pready  output  1  SHALL signal transfer completion.
REQ-013: xfer_cnt  output  16  SHALL count completed transfers.

Function
REQ-014: sel SHALL equal psel[SLAVE_IDX], and the register index SHALL equal paddr[2 +: log2(NUM_REGS)]; paddr[1:0] are ignored.
REQ-015: An address SHALL be out of range when paddr[31:2] >= NUM_REGS.
REQ-016: The FSM SHALL have exactly two states, IDLE and ACCESS, plus a 3-bit wait counter wcnt.
REQ-017: In IDLE, an edge with sel=1 and penable=0 SHALL move the FSM to ACCESS and load wcnt=WAIT_CYCLES; all other IDLE inputs keep IDLE.
REQ-018: pready SHALL be combinational and equal (state==ACCESS && wcnt==0); it is 0 at all other times.
REQ-019: In ACCESS with sel=1, penable=1 and wcnt!=0, each edge SHALL decrement wcnt by 1.
REQ-020: In ACCESS with sel=1, penable=1 and pready=1, the edge SHALL complete the transfer and return the FSM to IDLE.
REQ-021: A transfer SHALL last WAIT_CYCLES+1 access-phase cycles, i.e. 1 setup cycle plus WAIT_CYCLES+1 access cycles.
REQ-022: A completing write SHALL store pwdata into the indexed register on the completion edge; an out-of-range write SHALL be discarded with no register change.
REQ-023: prdata SHALL equal the indexed register when pready=1 and pwrite=0, 0 for out-of-range reads, and 0 at all other times.
REQ-024: xfer_cnt SHALL increment by 1 on every completion edge (reads, writes and out-of-range alike) and SHALL wrap from 0xFFFF to 0x0000.
REQ-025: In ACCESS, sel=0 SHALL abort the transfer: the FSM returns to IDLE with no write and no xfer_cnt change.
REQ-026: In ACCESS, sel=1 with penable=0 SHALL restart the transfer: the FSM stays in ACCESS, reloads wcnt=WAIT_CYCLES and commits no write.
REQ-027: Back-to-back transfers SHALL be supported: a setup in the cycle after completion is accepted from IDLE with no idle gap required.
REQ-028: pwrite, paddr and pwdata SHALL be sampled only at the completion edge; changes during wait cycles affect only the final result.
REQ-029: With WAIT_CYCLES=0, pready SHALL be 1 in the first access cycle.

Reset
REQ-030: preset_n=0 SHALL immediately force state=IDLE, wcnt=0, all registers=0, xfer_cnt=0, pready=0 and prdata=0, independent of pclk.
REQ-031: Reset asserted mid-transfer SHALL discard that transfer with no write and no count.
REQ-032: After deassertion, the first transfer SHALL be accepted from the next setup phase.

Verification
REQ-033: WAIT_CYCLES=1; write 0xA5A5_0001 to 0x08, then read 0x08 -> pready high in the 2nd access cycle of each transfer; read returns 0xA5A5_0001; xfer_cnt=2.
REQ-034: WAIT_CYCLES=0; back-to-back writes to 0x00 and 0x04 with no idle cycle -> each completes in 1 access cycle; both registers updated.
REQ-035: NUM_REGS=16; write to 0x40, then read 0x40 -> no register changes; prdata=0; xfer_cnt increments by 2.
REQ-036: Drop psel[SLAVE_IDX] during a wait cycle of a write -> target register unchanged; xfer_cnt unchanged; FSM in IDLE.
REQ-037: Drive psel=4'b0010 with SLAVE_IDX=0 -> pready stays 0; no state change.
REQ-038: Preload xfer_cnt to 0xFFFF via 65535 transfers, then perform one more transfer -> xfer_cnt=0x0000; assert preset_n=0 during a write -> all registers and outputs read 0.
